// File: rtl/fetch_sequencer_if.sv
// Bus between the fetch sequencer and its neighbours: PC register, main memory and the
// decode/execute stage. The sequencer uses the master modport, the environment the slave.
interface fetch_sequencer_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned WORD_W = 16
);
  // Control
  logic              start;
  logic              halt_req;
  logic              halted;
  logic              fetch_err;

  // PC register side
  logic [ADDR_W-1:0] op_of_pc;
  logic              increment_pc;
  logic              load_pc;
  logic [ADDR_W-1:0] DATA_pc;
  logic              branch_valid;
  logic [ADDR_W-1:0] branch_target;

  // Memory read port
  logic              mem_rd_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_ack;
  logic [WORD_W-1:0] mem_rd_data;

  // Instruction hand-off to decode/execute
  logic [WORD_W-1:0] ir_out;
  logic              ir_valid;
  logic              ir_ready;

  modport master (
    input  start, halt_req, op_of_pc, branch_valid, branch_target,
           mem_rd_ack, mem_rd_data, ir_ready,
    output increment_pc, load_pc, DATA_pc, mem_rd_req, mem_addr,
           ir_out, ir_valid, halted, fetch_err
  );

  modport slave (
    output start, halt_req, op_of_pc, branch_valid, branch_target,
           mem_rd_ack, mem_rd_data, ir_ready,
    input  increment_pc, load_pc, DATA_pc, mem_rd_req, mem_addr,
           ir_out, ir_valid, halted, fetch_err
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: samples the PC, reads memory, pulses the PC and hands the word on.
// Define FETCH_TIMEOUT_EN to build the READ wait counter and the sticky fetch_err timeout.
module fetch_sequencer #(
  parameter int unsigned ADDR_W         = 12,
  parameter int unsigned WORD_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               reset_fetch_n,
  fetch_sequencer_if.master bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StAddr, StRead, StIssue, StHalted} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] data_pc_q, data_pc_d;
  logic              handshake;
  logic              inc_pc;
  logic              ld_pc;
  logic              rd_timeout;

  assign handshake = (state_q == StIssue) && bus.ir_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wait_q, wait_d;
  logic            err_q, err_d;

  // The final ack-less READ cycle is the one whose pre-increment count is CntLast.
  assign rd_timeout = (state_q == StRead) && !bus.mem_rd_ack && (wait_q == CntLast);

  always_comb begin
    wait_d = wait_q;
    err_d  = err_q;
    if (state_q == StAddr) begin
      wait_d = '0;
    end else if (state_q == StRead && !bus.mem_rd_ack) begin
      wait_d = wait_q + 1'b1;
    end
    if (rd_timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_fetch_n) begin
    if (!reset_fetch_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wait_q <= wait_d;
      err_q  <= err_d;
    end
  end

  assign bus.fetch_err = err_q;
`else
  assign rd_timeout    = 1'b0;
  assign bus.fetch_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ar_d      = ar_q;
    ir_d      = ir_q;
    data_pc_d = data_pc_q;
    inc_pc    = 1'b0;
    ld_pc     = 1'b0;
    unique case (state_q)
      StIdle, StHalted: begin
        if (bus.start) begin
          state_d = StAddr;
        end
      end
      StAddr: begin
        ar_d    = bus.op_of_pc;
        state_d = StRead;
      end
      StRead: begin
        if (bus.mem_rd_ack) begin
          ir_d    = bus.mem_rd_data;
          inc_pc  = 1'b1;
          state_d = StIssue;
        end else if (rd_timeout) begin
          state_d = StHalted;
        end
      end
      StIssue: begin
        if (handshake) begin
          if (bus.branch_valid) begin
            ld_pc     = 1'b1;
            data_pc_d = bus.branch_target;
          end
          state_d = bus.halt_req ? StHalted : StAddr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_fetch_n) begin
    if (!reset_fetch_n) begin
      state_q   <= StIdle;
      ar_q      <= '0;
      ir_q      <= '0;
      data_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      ar_q      <= ar_d;
      ir_q      <= ir_d;
      data_pc_q <= data_pc_d;
    end
  end

  assign bus.mem_rd_req   = (state_q == StRead);
  assign bus.mem_addr     = ar_q;
  assign bus.ir_out       = ir_q;
  assign bus.ir_valid     = (state_q == StIssue);
  assign bus.halted       = (state_q == StHalted);
  assign bus.increment_pc = inc_pc;
  assign bus.load_pc      = ld_pc;
  // Branch target is visible in the load cycle itself, then held.
  assign bus.DATA_pc      = ld_pc ? bus.branch_target : data_pc_q;

`ifndef SYNTHESIS
  a_pulse_excl: assert property (@(posedge clk) disable iff (!reset_fetch_n)
    !(inc_pc && ld_pc));
  a_addr_hold: assert property (@(posedge clk) disable iff (!reset_fetch_n)
    (bus.mem_rd_req && !bus.mem_rd_ack) |=> $stable(bus.mem_addr));
  a_ir_hold: assert property (@(posedge clk) disable iff (!reset_fetch_n)
    (bus.ir_valid && !bus.ir_ready) |=> (bus.ir_valid && $stable(bus.ir_out)));
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a PC register and memory around the DUT, and an
// instruction-stream scoreboard tracking which address must be fetched and issued next.
module tb_fetch_sequencer;
  localparam int unsigned ADDR_W         = 12;
  localparam int unsigned WORD_W         = 16;
  localparam int unsigned TIMEOUT_CYCLES = 8;

  logic clk = 1'b0;
  logic reset_fetch_n;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

  fetch_sequencer #(
    .ADDR_W        (ADDR_W),
    .WORD_W        (WORD_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_fetch_n(reset_fetch_n),
    .bus          (bus)
  );

  // Environment: PC register driven by the DUT pulses, and a memory image.
  logic [ADDR_W-1:0] pc_reg;
  logic              pc_set;
  logic [ADDR_W-1:0] pc_init;
  logic [WORD_W-1:0] mem_img [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (pc_set)                pc_reg <= pc_init;
    else if (bus.increment_pc) pc_reg <= pc_reg + 1'b1;
    else if (bus.load_pc)      pc_reg <= bus.DATA_pc;
  end
  assign bus.op_of_pc = pc_reg;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard / responder state
  logic [ADDR_W-1:0] model_pc, req_addr, last_ld, k_tgt;
  logic [WORD_W-1:0] ir_hold;
  int cyc = 0, rd_cnt = 0, iss_cnt = 0, n_issued = 0, req_cycles = 0;
  int last_req_cyc = 0, req_gap = 0, valid_len = 0;
  int k_lat = 0, k_rdy = 0;
  bit k_br = 0, k_halt = 0, rand_knobs = 0, auto_start = 0, start_force = 0, expect_halt = 0;

  task automatic rand_knob_set();
    k_lat  = $urandom_range(0, 5);
    k_rdy  = $urandom_range(0, 3);
    k_br   = ($urandom_range(0, 3) == 0);
    k_tgt  = ADDR_W'($urandom);
    k_halt = ($urandom_range(0, 7) == 0);
  endtask

  // One clock: sample at negedge, answer the DUT, then check the combinational pulses.
  task automatic cycle();
    bit ack, hs;
    ack = 1'b0;
    hs  = 1'b0;
    @(negedge clk);
    cyc++;
    if (expect_halt) begin
      check_eq("halted_after_hs", bus.halted, 1);
      check_eq("no_req_when_halted", bus.mem_rd_req, 0);
      expect_halt = 0;
    end
    bus.start         = start_force | (auto_start & ($urandom_range(0, 3) == 0));
    bus.mem_rd_data   = WORD_W'($urandom);
    bus.ir_ready      = 1'($urandom_range(0, 1));
    bus.branch_valid  = 1'($urandom_range(0, 1));
    bus.branch_target = ADDR_W'($urandom);
    bus.halt_req      = 1'($urandom_range(0, 1));
    if (bus.mem_rd_req) begin
      if (rd_cnt == 0) begin
        check_eq("fetch_addr", bus.mem_addr, model_pc);
        req_addr     = bus.mem_addr;
        req_gap      = cyc - last_req_cyc;
        last_req_cyc = cyc;
      end else begin
        check_eq("addr_stable", bus.mem_addr, req_addr);
      end
      if (rd_cnt >= k_lat) begin
        ack             = 1'b1;
        bus.mem_rd_data = mem_img[bus.mem_addr];
      end
      bus.mem_rd_ack = ack;
      rd_cnt++;
      req_cycles++;
    end else begin
      rd_cnt         = 0;
      bus.mem_rd_ack = 1'($urandom_range(0, 1));
    end
    if (bus.ir_valid) begin
      bus.ir_ready = 1'b0;
      if (iss_cnt == 0) ir_hold = bus.ir_out;
      else check_eq("ir_stable", bus.ir_out, ir_hold);
      if (iss_cnt >= k_rdy) begin
        hs                = 1'b1;
        bus.ir_ready      = 1'b1;
        bus.branch_valid  = k_br;
        bus.branch_target = k_tgt;
        bus.halt_req      = k_halt;
      end
      iss_cnt++;
    end else begin
      iss_cnt = 0;
    end
    #1;
    check_eq("inc_pulse", bus.increment_pc, ack);
    check_eq("load_pulse", bus.load_pc, hs && k_br);
    if (hs && k_br) begin
      check_eq("data_pc", bus.DATA_pc, k_tgt);
      last_ld = k_tgt;
    end else begin
      check_eq("data_pc_hold", bus.DATA_pc, last_ld);
    end
    if (hs) begin
      check_eq("ir_word", bus.ir_out, mem_img[model_pc]);
      model_pc  = k_br ? k_tgt : model_pc + 1'b1;
      valid_len = iss_cnt;
      n_issued++;
      if (k_halt) expect_halt = 1;
      if (rand_knobs) rand_knob_set();
    end
  endtask

  task automatic run_until_issued(input int target, input int budget);
    int c0;
    c0 = cyc;
    while (n_issued < target && (cyc - c0) < budget) cycle();
    check_eq("issued_count", n_issued, target);
  endtask

  task automatic do_reset(input logic [ADDR_W-1:0] pc0);
    reset_fetch_n     = 1'b0;
    bus.start         = 1'b0;
    bus.halt_req      = 1'b0;
    bus.branch_valid  = 1'b0;
    bus.branch_target = '0;
    bus.mem_rd_ack    = 1'b0;
    bus.mem_rd_data   = '0;
    bus.ir_ready      = 1'b0;
    pc_set            = 1'b1;
    pc_init           = pc0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", bus.mem_rd_req, 0);
    check_eq("rst_addr", bus.mem_addr, 0);
    check_eq("rst_ir", bus.ir_out, 0);
    check_eq("rst_valid", bus.ir_valid, 0);
    check_eq("rst_data_pc", bus.DATA_pc, 0);
    check_eq("rst_pulses", {bus.increment_pc, bus.load_pc}, 0);
    check_eq("rst_halted", bus.halted, 0);
    check_eq("rst_err", bus.fetch_err, 0);
    reset_fetch_n = 1'b1;
    pc_set        = 1'b0;
    model_pc      = pc0;
    last_ld       = '0;
    rd_cnt        = 0;
    iss_cnt       = 0;
    expect_halt   = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    for (int i = 0; i < (1 << ADDR_W); i++) mem_img[i] = WORD_W'($urandom);
    mem_img[12'h010] = 16'h7800;

    // Basic fetch at 0x010, same-cycle ack, ready at once
    do_reset(12'h010);
    start_force = 1;
    cycle();
    start_force = 0;
    run_until_issued(2, 20);
    check_eq("valid_len_1", valid_len, 1);
    check_eq("addr_to_addr_gap", req_gap, 3);

    // Memory ack delayed 4 cycles
    k_lat = 4;
    req_cycles = 0;
    run_until_issued(3, 30);
    check_eq("req_cycles_lat4", req_cycles, 5);

    // Branch on the handshake, then fetch from the target
    k_lat = 0; k_br = 1; k_tgt = 12'h123;
    run_until_issued(4, 20);
    k_br = 0;
    run_until_issued(5, 20);

    // Consumer stalls for 6 cycles
    k_rdy = 6;
    run_until_issued(6, 30);
    check_eq("valid_len_stall", valid_len, 7);
    k_rdy = 0;

    // Halt on the handshake, stay halted, then resume
    k_halt = 1;
    run_until_issued(7, 20);
    k_halt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check_eq("stay_halted", {bus.halted, bus.mem_rd_req}, 2'b10);
    end
    start_force = 1;
    cycle();
    start_force = 0;
    run_until_issued(8, 20);

    // Asynchronous reset in the middle of READ
    k_lat = 10;
    g = 0;
    while (!bus.mem_rd_req && g < 10) begin cycle(); g++; end
    cycle();
    check_eq("in_read_before_rst", bus.mem_rd_req, 1);
    reset_fetch_n = 1'b0;
    #1;
    check_eq("async_rst_req", bus.mem_rd_req, 0);
    check_eq("async_rst_valid", bus.ir_valid, 0);
    check_eq("async_rst_err", bus.fetch_err, 0);
    check_eq("async_rst_addr", bus.mem_addr, 0);

    // Address wrap is the PC register's business: 0xFFE, 0xFFF, 0x000
    do_reset(12'hFFE);
    k_lat = 0;
    start_force = 1;
    cycle();
    start_force = 0;
    run_until_issued(n_issued + 3, 30);
    check_eq("wrapped_pc", model_pc, 12'h001);

    // Randomized stream with branches, stalls and halts
    rand_knobs = 1;
    auto_start = 1;
    rand_knob_set();
    run_until_issued(n_issued + 200, 8000);
    rand_knobs = 0;
    auto_start = 0;

`ifdef FETCH_TIMEOUT_EN
    // Memory never answers: error after TIMEOUT_CYCLES READ cycles, sticky across start
    do_reset(12'h200);
    k_lat = 100000; k_rdy = 0; k_br = 0; k_halt = 0;
    req_cycles = 0;
    start_force = 1;
    cycle();
    start_force = 0;
    g = 0;
    while (!bus.halted && g < 40) begin cycle(); g++; end
    check_eq("timeout_req_cycles", req_cycles, TIMEOUT_CYCLES);
    check_eq("timeout_halted", bus.halted, 1);
    check_eq("timeout_err", bus.fetch_err, 1);
    start_force = 1;
    cycle();
    start_force = 0;
    cycle();
    cycle();
    check_eq("err_sticky", {bus.fetch_err, bus.mem_rd_req}, 2'b11);
    do_reset(12'h000);
`else
    // Without the timeout feature READ waits indefinitely
    do_reset(12'h200);
    k_lat = 100000; k_rdy = 0; k_br = 0; k_halt = 0;
    start_force = 1;
    cycle();
    start_force = 0;
    repeat (3 * TIMEOUT_CYCLES) cycle();
    check_eq("no_timeout", {bus.mem_rd_req, bus.halted, bus.fetch_err}, 3'b100);
    do_reset(12'h000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the basic computer; it is the control side that drives the program counter register.
- Samples the PC value, issues a memory read handshake, and latches the returned word as the instruction.
- Pulses the PC's increment_pc and load_pc controls, then presents the instruction to the decode/execute stage over a valid/ready handshake.
- Sits between the PC register, main memory and the control unit.

Parameters:
ADDR_W, 12, address width; matches PC width
WORD_W, 16, memory word / instruction width
TIMEOUT_CYCLES, 255, max READ wait cycles before error (used only with FETCH_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
reset_fetch_n  input  1  reset, asynchronous, active-low
start  input  1  begin or resume fetching from IDLE/HALTED
halt_req  input  1  stop after the current instruction is accepted
op_of_pc  input  ADDR_W  current PC value
increment_pc  output  1  one-cycle PC increment pulse
load_pc  output  1  one-cycle PC load pulse
DATA_pc  output  ADDR_W  PC load value (branch target)
branch_valid  input  1  redirect PC; qualified by ISSUE handshake
branch_target  input  ADDR_W  redirect address
mem_rd_req  output  1  memory read request
mem_addr  output  ADDR_W  read address (AR)
mem_rd_ack  input  1  read data valid this cycle
mem_rd_data  input  WORD_W  read data
ir_out  output  WORD_W  instruction register
ir_valid  output  1  ir_out holds an unconsumed instruction
ir_ready  input  1  consumer accepts ir_out
halted  output  1  FSM in HALTED
fetch_err  output  1  sticky read-timeout error

Behaviour:
- Reset (async, reset_fetch_n=0) forces state IDLE immediately.
  - All outputs go to 0, including ar/mem_addr, ir_out, DATA_pc and fetch_err.
  - Any outstanding mem_rd_req drops at once; no PC pulse is generated.
- States: IDLE, ADDR, READ, ISSUE, HALTED.
- IDLE: stays until start=1, then ADDR next cycle. halt_req is ignored.
- ADDR (exactly 1 cycle): ar <= op_of_pc; next state READ.
- READ:
  - mem_rd_req=1; mem_addr=ar, held stable until ack.
  - Cycle with mem_rd_ack=1: ir_out <= mem_rd_data, increment_pc=1 for that cycle only, next state ISSUE.
  - mem_rd_ack outside READ is ignored.
- ISSUE:
  - ir_valid=1; ir_out stable.
  - Handshake = ir_valid & ir_ready.
  - On handshake with branch_valid=1: load_pc=1 and DATA_pc=branch_target in that same cycle.
  - After handshake: if halt_req=1 go to HALTED, else go to ADDR.
  - branch_valid and halt_req are ignored without a handshake.
- HALTED: halted=1, no requests. start=1 goes to ADDR.
- Outputs: increment_pc and load_pc are Moore/Mealy pulses, never asserted together, never longer than 1 cycle.
  - DATA_pc holds its last value when load_pc=0.
- Minimum throughput: 3 cycles per instruction (ADDR, READ with same-cycle ack, ISSUE with ready=1).
- Address wrap: PC arithmetic is owned by the PC register (0xFFF+1 -> 0x000). This block fetches whatever op_of_pc shows in ADDR.
- Simultaneous start and halt_req in IDLE/HALTED: start wins.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro:
  - A wait counter clears on entering READ and increments on each READ cycle without ack.
  - When the count reaches TIMEOUT_CYCLES without ack: fetch_err <= 1 (sticky until reset), mem_rd_req drops, go to HALTED, no increment_pc.
  - start from HALTED does not clear fetch_err.
- Without the macro: no counter is built, fetch_err is tied 0, and READ waits indefinitely.

Test Plan:
- Reset, start=1, op_of_pc=0x010, memory acks on first READ cycle with 0x7800, ir_ready=1 -> mem_addr=0x010, increment_pc pulses exactly once, ir_out=0x7800, ir_valid high 1 cycle, next ADDR 3 cycles after previous ADDR.
- Memory ack delayed 4 cycles -> mem_rd_req held 5 cycles with mem_addr constant, single increment_pc on ack cycle.
- In ISSUE, ir_ready=1 with branch_valid=1, branch_target=0x123 -> load_pc=1, DATA_pc=0x123 that cycle, never coincident with increment_pc.
- ir_ready held 0 for 6 cycles -> ir_valid and ir_out stable, no PC pulses, no memory request.
- halt_req=1 during ISSUE handshake -> halted=1 next cycle, no further mem_rd_req; start=1 -> ADDR resumes.
- reset_fetch_n low mid-READ -> mem_rd_req, ir_valid, fetch_err 0 without waiting for clk. With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8 and no ack -> fetch_err=1, halted=1 after 8 READ cycles.
